// File: rtl/mux_n_to_1_pipe.sv
// N-channel, WIDTH-bit registered multiplexer with valid/ready on every input and on the output.
// Define MUX_N_TO_1_PIPE_ROUND_ROBIN_EN to ignore sel and arbitrate round-robin instead.
module mux_n_to_1_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic [WIDTH-1:0] chan_data [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign chan_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  logic             can_accept;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic             in_xfer;
  logic             out_xfer;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;

  // Register is free when empty or being drained this cycle.
  assign can_accept = !out_valid_q || out_ready;

`ifdef MUX_N_TO_1_PIPE_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             unused_sel;

  assign unused_sel = ^sel;

  // First valid channel at or after ptr, wrapping modulo CHANNELS.
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!grant_valid && in_valid[SEL_W'(idx)]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer) begin
      ptr_d = (32'(grant) == CHANNELS - 1) ? '0 : grant + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign grant = sel;

  // Only non-power-of-two channel counts can see an out-of-range select.
  if (CHANNELS == (1 << SEL_W)) begin : g_sel_full
    assign grant_valid = 1'b1;
  end else begin : g_sel_partial
    assign grant_valid = (sel < SEL_W'(CHANNELS));
  end
`endif

  always_comb begin
    in_ready = '0;
    if (!reset && grant_valid) begin
      in_ready[grant] = can_accept;
    end
  end

  assign in_xfer  = !reset && grant_valid && in_valid[grant] && can_accept;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      out_data_d  = chan_data[grant];
      out_chan_d  = grant;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Directed self-checking bench for mux_n_to_1_pipe (4-channel main instance, 3-channel side instance).
module tb_mux_n_to_1_pipe;

  logic         clk;
  logic         reset;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_chan;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3;
  logic [31:0]  out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic [1:0]   out_chan3;

  int checks = 0;
  int errors = 0;

  mux_n_to_1_pipe #(.WIDTH(32), .CHANNELS(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  mux_n_to_1_pipe #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_chan  (out_chan3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    in_data[k*32 +: 32] = v;
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic v,
                           input logic [1:0] c);
    check({tag, ".data"}, 64'(out_data), 64'(d));
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".chan"}, 64'(out_chan), 64'(c));
  endtask

  initial begin
    reset      = 1'b1;
    in_data    = '0;
    in_valid   = '0;
    sel        = '0;
    out_ready  = 1'b0;
    in_data3   = '0;
    in_valid3  = '0;
    sel3       = '0;
    out_ready3 = 1'b0;
    #2;
    check_out("reset", 32'h0, 1'b0, 2'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;

`ifdef MUX_N_TO_1_PIPE_ROUND_ROBIN_EN
    // Round-robin: all channels valid, data = channel id.
    for (int k = 0; k < 4; k++) set_ch(k, 32'(k));
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("rr.in_ready", 64'(in_ready), 64'(4'b0001 << (n % 4)));
      tick();
      check_out("rr.seq", 32'(n % 4), 1'b1, 2'(n % 4));
    end
    // Pointer now 1: channels 0 and 3 valid -> 3 then 0.
    in_valid = 4'b1001;
    #1;
    check("rr.gap.in_ready3", 64'(in_ready), 64'(4'b1000));
    tick();
    check_out("rr.gap3", 32'd3, 1'b1, 2'd3);
    #1;
    check("rr.gap.in_ready0", 64'(in_ready), 64'(4'b0001));
    tick();
    check_out("rr.gap0", 32'd0, 1'b1, 2'd0);
    in_valid = 4'h0;
    tick();
    check("rr.drain.valid", 64'(out_valid), 64'(1'b0));
`else
    // 1: single word from channel 2.
    sel       = 2'd2;
    set_ch(2, 32'hDEADBEEF);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    check("t1.in_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    check_out("t1.out", 32'hDEADBEEF, 1'b1, 2'd2);

    // 2: stall for 3 cycles, then release with no bubble.
    out_ready = 1'b0;
    in_valid  = 4'hF;
    set_ch(2, 32'h11111111);
    for (int n = 0; n < 3; n++) begin
      #1;
      check("t2.stall.in_ready", 64'(in_ready), 64'(4'b0000));
      tick();
      check_out("t2.stall", 32'hDEADBEEF, 1'b1, 2'd2);
    end
    out_ready = 1'b1;
    #1;
    check("t2.release.in_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    check_out("t2.release", 32'h11111111, 1'b1, 2'd2);
    in_valid = 4'h0;
    tick();
    check_out("t2.drain", 32'h11111111, 1'b0, 2'd2);

    // 3: stream 0..7 from channel 1.
    sel      = 2'd1;
    in_valid = 4'b0010;
    for (int n = 0; n < 8; n++) begin
      set_ch(1, 32'(n));
      tick();
      check_out("t3.stream", 32'(n), 1'b1, 2'd1);
    end
    in_valid = 4'h0;
    tick();
    check("t3.end.valid", 64'(out_valid), 64'(1'b0));

    // 6: 3-channel instance, out-of-range select.
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    out_ready3 = 1'b1;
    in_data3   = {32'h33333333, 32'h22222222, 32'h11111111};
    #1;
    check("t6.in_ready", 64'(in_ready3), 64'(3'b000));
    tick();
    tick();
    check("t6.valid", 64'(out_valid3), 64'(1'b0));
    sel3 = 2'd2;
    #1;
    check("t6.sel2.in_ready", 64'(in_ready3), 64'(3'b100));
    tick();
    check("t6.sel2.data", 64'(out_data3), 64'(32'h33333333));
    check("t6.sel2.chan", 64'(out_chan3), 64'(2'd2));
    in_valid3 = 3'b000;
`endif

    // 4: reset between edges drops the held word at once.
    sel       = 2'd0;
    set_ch(0, 32'hA5A5A5A5);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    tick();
    check_out("t4.loaded", 32'hA5A5A5A5, 1'b1, 2'd0);
    in_valid  = 4'h0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("t4.async", 32'h0, 1'b0, 2'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t4.after.valid", 64'(out_valid), 64'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
